// File: rtl/vend_select_if.sv
// Key-pulse inputs and display/actuator outputs of the vending selection controller.
interface vend_select_if;
  logic [3:0] key_item;
  logic       key_coin1;
  logic       key_coin5;
  logic       key_confirm;
  logic       key_cancel;
  logic [7:0] balance;
  logic [7:0] price;
  logic [1:0] item;
  logic       busy;
  logic       vend_valid;
  logic       change_valid;
  logic [7:0] change;
  logic       err;

  modport master (
    output key_item, key_coin1, key_coin5, key_confirm, key_cancel,
    input  balance, price, item, busy, vend_valid, change_valid, change, err
  );

  modport slave (
    input  key_item, key_coin1, key_coin5, key_confirm, key_cancel,
    output balance, price, item, busy, vend_valid, change_valid, change, err
  );
endinterface

// File: rtl/vend_select_fsm.sv
// Vending selection/payment controller: item select, coin credit, vend strobe, change/refund.
// Optional idle timeout in SEL enabled by defining VEND_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transaction, waiting for a valid item key
// SEL    | item chosen, accepting coins / confirm / cancel
// VEND   | one cycle, vend_valid high, change computed
// CHG    | one cycle, change strobe if change is nonzero
// REFUND | one cycle, refund strobe if balance is nonzero
module vend_select_fsm #(
  parameter logic [7:0]      PRICE0      = 8'd3,
  parameter logic [7:0]      PRICE1      = 8'd5,
  parameter logic [7:0]      PRICE2      = 8'd8,
  parameter logic [7:0]      PRICE3      = 8'd12,
  parameter int              TO_W        = 27,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 27'd120000000
) (
  input  logic         clk,
  input  logic         rst,
  vend_select_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEL    = 3'd1,
    S_VEND   = 3'd2,
    S_CHG    = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_balance, w_balance_nxt;
  logic [7:0] r_price, w_price_nxt;
  logic [1:0] r_item, w_item_nxt;
  logic       r_busy;
  logic       r_vend_valid, w_vend_valid_nxt;
  logic       r_change_valid, w_change_valid_nxt;
  logic [7:0] r_change, w_change_nxt;
  logic       r_err, w_err_nxt;

  logic       w_item_ok;
  logic [1:0] w_item_code;
  logic [7:0] w_item_price;
  logic [8:0] w_coin_sum;
  logic [7:0] w_coin_bal;
  logic [7:0] w_diff;

`ifdef VEND_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
`endif

  assign w_item_ok   = (bus.key_item != 4'd0) && ((bus.key_item & (bus.key_item - 4'd1)) == 4'd0);
  assign w_item_code = {bus.key_item[3] | bus.key_item[2], bus.key_item[3] | bus.key_item[1]};
  assign w_coin_sum  = {1'b0, r_balance} + {8'd0, bus.key_coin1} + (bus.key_coin5 ? 9'd5 : 9'd0);
  assign w_coin_bal  = w_coin_sum[8] ? 8'd255 : w_coin_sum[7:0];
  // Only reached from VEND, where balance >= price is guaranteed
  assign w_diff      = r_balance - r_price;

  always_comb begin
    case (w_item_code)
      2'd0:    w_item_price = PRICE0;
      2'd1:    w_item_price = PRICE1;
      2'd2:    w_item_price = PRICE2;
      default: w_item_price = PRICE3;
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_balance_nxt      = r_balance;
    w_price_nxt        = r_price;
    w_item_nxt         = r_item;
    w_vend_valid_nxt   = 1'b0;
    w_change_valid_nxt = 1'b0;
    w_change_nxt       = 8'd0;
    w_err_nxt          = 1'b0;
`ifdef VEND_TIMEOUT_EN
    w_to_cnt_nxt       = r_to_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_item_ok) begin
          w_state_nxt   = S_SEL;
          w_item_nxt    = w_item_code;
          w_price_nxt   = w_item_price;
          w_balance_nxt = 8'd0;
`ifdef VEND_TIMEOUT_EN
          w_to_cnt_nxt  = '0;
`endif
        end
      end
      S_SEL: begin
        if (bus.key_cancel) begin
          w_state_nxt        = S_REFUND;
          w_change_valid_nxt = (r_balance != 8'd0);
          w_change_nxt       = r_balance;
        end else if (bus.key_confirm) begin
          if (r_balance >= r_price) begin
            w_state_nxt      = S_VEND;
            w_vend_valid_nxt = 1'b1;
          end else begin
            w_err_nxt        = 1'b1;
`ifdef VEND_TIMEOUT_EN
            w_to_cnt_nxt     = '0;
`endif
          end
        end else if (bus.key_coin1 || bus.key_coin5) begin
          w_balance_nxt = w_coin_bal;
`ifdef VEND_TIMEOUT_EN
          w_to_cnt_nxt  = '0;
`endif
        end else if (w_item_ok && (r_balance == 8'd0)) begin
          w_item_nxt    = w_item_code;
          w_price_nxt   = w_item_price;
`ifdef VEND_TIMEOUT_EN
          w_to_cnt_nxt  = '0;
`endif
        end else begin
`ifdef VEND_TIMEOUT_EN
          if (r_to_cnt == TO_LAST) begin
            w_state_nxt        = S_REFUND;
            w_change_valid_nxt = (r_balance != 8'd0);
            w_change_nxt       = r_balance;
          end else begin
            w_to_cnt_nxt       = r_to_cnt + 1'b1;
          end
`endif
        end
      end
      S_VEND: begin
        w_state_nxt        = S_CHG;
        w_change_valid_nxt = (w_diff != 8'd0);
        w_change_nxt       = w_diff;
      end
      S_CHG, S_REFUND: begin
        w_state_nxt   = S_IDLE;
        w_balance_nxt = 8'd0;
        w_price_nxt   = 8'd0;
        w_item_nxt    = 2'd0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_balance      <= 8'd0;
      r_price        <= 8'd0;
      r_item         <= 2'd0;
      r_busy         <= 1'b0;
      r_vend_valid   <= 1'b0;
      r_change_valid <= 1'b0;
      r_change       <= 8'd0;
      r_err          <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      r_to_cnt       <= '0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_balance      <= w_balance_nxt;
      r_price        <= w_price_nxt;
      r_item         <= w_item_nxt;
      r_busy         <= (w_state_nxt != S_IDLE);
      r_vend_valid   <= w_vend_valid_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_change       <= w_change_nxt;
      r_err          <= w_err_nxt;
`ifdef VEND_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt_nxt;
`endif
    end
  end

  assign bus.balance      = r_balance;
  assign bus.price        = r_price;
  assign bus.item         = r_item;
  assign bus.busy         = r_busy;
  assign bus.vend_valid   = r_vend_valid;
  assign bus.change_valid = r_change_valid;
  assign bus.change       = r_change;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_vend_select_fsm.sv
// Self-checking bench for vend_select_fsm against a transaction-level purchase model.
// Timeout scenario runs when VEND_TIMEOUT_EN is defined; otherwise SEL is checked to hold.
`timescale 1ns/1ps
module tb_vend_select_fsm;
  localparam int TB_TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_select_if bus_if();

  vend_select_fsm #(.TIMEOUT_CYC(27'(TB_TO))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct packed {
    logic [7:0] bal;
    logic [7:0] price;
    logic [1:0] item;
    logic       busy;
    logic       vend;
    logic       chgv;
    logic [7:0] chg;
    logic       err;
  } frame_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  frame_t exp_f;
  frame_t q_fr[$];
  bit     m_sel;
  int     m_item, m_price, m_bal, m_to;
  int     prices[4] = '{3, 5, 8, 12};

  function automatic frame_t observe();
    frame_t f;
    f.bal   = bus_if.balance;
    f.price = bus_if.price;
    f.item  = bus_if.item;
    f.busy  = bus_if.busy;
    f.vend  = bus_if.vend_valid;
    f.chgv  = bus_if.change_valid;
    f.chg   = bus_if.change;
    f.err   = bus_if.err;
    return f;
  endfunction

  function automatic frame_t cur_frame();
    frame_t f = '0;
    f.bal   = 8'(m_bal);
    f.price = 8'(m_price);
    f.item  = 2'(m_item);
    f.busy  = m_sel;
    return f;
  endfunction

  function automatic void model_clear();
    m_sel = 0; m_item = 0; m_price = 0; m_bal = 0; m_to = 0;
  endfunction

  function automatic void do_refund();
    exp_f      = cur_frame();
    exp_f.chgv = (m_bal != 0);
    exp_f.chg  = 8'(m_bal);
    model_clear();
    q_fr.push_back(cur_frame());
  endfunction

  function automatic void do_vend();
    frame_t f;
    exp_f      = cur_frame();
    exp_f.vend = 1'b1;
    f          = cur_frame();
    f.chgv     = (m_bal - m_price) != 0;
    f.chg      = 8'(m_bal - m_price);
    q_fr.push_back(f);
    model_clear();
    q_fr.push_back(cur_frame());
  endfunction

  // Purchase rules applied to one cycle of key pulses; sets exp_f to the outputs seen next cycle.
  function automatic void model_step(input logic [3:0] it, input logic c1, c5, cf, cc);
    bit onehot = ($countones(it) == 1);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (it[i]) idx = i;
    if (q_fr.size() > 0) begin
      exp_f = q_fr.pop_front();
    end else if (!m_sel) begin
      if (onehot) begin
        m_sel = 1; m_item = idx; m_price = prices[idx]; m_bal = 0; m_to = 0;
      end
      exp_f = cur_frame();
    end else if (cc) begin
      do_refund();
    end else if (cf) begin
      if (m_bal >= m_price) do_vend();
      else begin
        m_to = 0;
        exp_f = cur_frame();
        exp_f.err = 1'b1;
      end
    end else if (c1 || c5) begin
      m_bal = m_bal + (c1 ? 1 : 0) + (c5 ? 5 : 0);
      if (m_bal > 255) m_bal = 255;
      m_to = 0;
      exp_f = cur_frame();
    end else if (onehot && m_bal == 0) begin
      m_item = idx; m_price = prices[idx]; m_to = 0;
      exp_f = cur_frame();
    end else begin
`ifdef VEND_TIMEOUT_EN
      if (m_to == TB_TO - 1) begin
        do_refund();
        return;
      end
      m_to++;
`endif
      exp_f = cur_frame();
    end
  endfunction

  task automatic step(input logic [3:0] it, input logic c1, c5, cf, cc);
    bus_if.key_item    = it;
    bus_if.key_coin1   = c1;
    bus_if.key_coin5   = c5;
    bus_if.key_confirm = cf;
    bus_if.key_cancel  = cc;
    model_step(it, c1, c5, cf, cc);
    @(posedge clk);
    @(negedge clk);
    bus_if.key_item    = 4'd0;
    bus_if.key_coin1   = 1'b0;
    bus_if.key_coin5   = 1'b0;
    bus_if.key_confirm = 1'b0;
    bus_if.key_cancel  = 1'b0;
  endtask

  task automatic idle();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (observe() !== frame_t'(0)) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%h required=0", observe());
    end
    rst = 1'b0;
    idle();
    n_checks++;
    if (observe() !== exp_f) begin
      n_fail++;
      $display("FAIL reset_idle actual=%h required=%h", observe(), exp_f);
    end
  endtask

  task automatic test_reset_mid_sel();
    step(4'b0010, 0, 0, 0, 0);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    n_checks++;
    if (bus_if.balance !== 8'd7 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sel_balance actual=%0d busy=%b required=7 busy=1", bus_if.balance, bus_if.busy);
    end
    #2 rst = 1'b1;
    model_clear();
    q_fr.delete();
    exp_f = '0;
    #1;
    n_checks++;
    if (observe() !== frame_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset actual=%h required=0", observe());
    end
    @(negedge clk);
    rst = 1'b0;
    idle();
    n_checks++;
    if (observe() !== frame_t'(0) || bus_if.change_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_refund actual=%h required=0", observe());
    end
  endtask

  task automatic test_vend_change();
    step(4'b0100, 0, 0, 0, 0);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 0, 0, 1, 0);
    n_checks++;
    if (bus_if.vend_valid !== 1'b1 || bus_if.item !== 2'd2 || observe() !== exp_f) begin
      n_fail++;
      $display("FAIL vend_strobe actual=%h required=%h (vend=1 item=2)", observe(), exp_f);
    end
    idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd2 || bus_if.vend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL vend_change actual=%b/%0d required=1/2", bus_if.change_valid, bus_if.change);
    end
    idle();
    n_checks++;
    if (observe() !== frame_t'(0)) begin
      n_fail++;
      $display("FAIL vend_to_idle actual=%h required=0", observe());
    end
  endtask

  task automatic test_insufficient();
    step(4'b0010, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    step(4'd0, 0, 0, 1, 0);
    n_checks++;
    if (bus_if.err !== 1'b1 || bus_if.balance !== 8'd1 || bus_if.vend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_strobe actual=err%b bal%0d required=err1 bal1", bus_if.err, bus_if.balance);
    end
    step(4'd0, 1, 1, 0, 0);
    n_checks++;
    if (bus_if.err !== 1'b0 || bus_if.balance !== 8'd7) begin
      n_fail++;
      $display("FAIL both_coins actual=err%b bal%0d required=err0 bal7", bus_if.err, bus_if.balance);
    end
    step(4'd0, 0, 0, 1, 0);
    n_checks++;
    if (bus_if.vend_valid !== 1'b1 || bus_if.item !== 2'd1) begin
      n_fail++;
      $display("FAIL vend_item1 actual=%b/%0d required=1/1", bus_if.vend_valid, bus_if.item);
    end
    idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd2) begin
      n_fail++;
      $display("FAIL change_item1 actual=%b/%0d required=1/2", bus_if.change_valid, bus_if.change);
    end
    idle();
  endtask

  task automatic test_cancel_priority();
    step(4'b1000, 0, 0, 0, 0);
    step(4'd0, 0, 1, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    n_checks++;
    if (bus_if.item !== 2'd3 || bus_if.price !== 8'd12 || observe() !== exp_f) begin
      n_fail++;
      $display("FAIL reselect_ignored actual=%0d/%0d required=3/12", bus_if.item, bus_if.price);
    end
    step(4'd0, 0, 0, 1, 1);
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd5 || bus_if.vend_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_refund actual=%b/%0d/vend%b required=1/5/vend0",
               bus_if.change_valid, bus_if.change, bus_if.vend_valid);
    end
    idle();
    n_checks++;
    if (bus_if.busy !== 1'b0 || bus_if.change_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL refund_idle actual=busy%b chg%b required=0/0", bus_if.busy, bus_if.change_valid);
    end
  endtask

  task automatic test_saturation();
    step(4'b0001, 0, 0, 0, 0);
    for (int i = 0; i < 52; i++) step(4'd0, 0, 1, 0, 0);
    n_checks++;
    if (bus_if.balance !== 8'd255 || bus_if.err !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate actual=%0d err%b required=255 err0", bus_if.balance, bus_if.err);
    end
    step(4'd0, 0, 0, 1, 0);
    idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd252) begin
      n_fail++;
      $display("FAIL sat_change actual=%b/%0d required=1/252", bus_if.change_valid, bus_if.change);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    step(4'b0001, 0, 0, 0, 0);
    step(4'd0, 0, 1, 0, 0);
    step(4'd0, 0, 0, 1, 0);
    idle();
    step(4'b0100, 0, 0, 0, 0);
    step(4'b0010, 0, 0, 0, 0);
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.item !== 2'd1 || bus_if.price !== 8'd5 || observe() !== exp_f) begin
      n_fail++;
      $display("FAIL item_at_n3 actual=busy%b item%0d price%0d required=1/1/5",
               bus_if.busy, bus_if.item, bus_if.price);
    end
    step(4'd0, 0, 0, 0, 1);
    idle();
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    step(4'b0001, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    for (int i = 0; i < TB_TO - 1; i++) idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early actual=chg%b busy%b required=0/1", bus_if.change_valid, bus_if.busy);
    end
    idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd1 || observe() !== exp_f) begin
      n_fail++;
      $display("FAIL timeout_refund actual=%b/%0d required=1/1", bus_if.change_valid, bus_if.change);
    end
    idle();
    n_checks++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle actual=%b required=0", bus_if.busy);
    end
    step(4'b0001, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    for (int i = 0; i < TB_TO - 2; i++) idle();
    step(4'd0, 1, 0, 0, 0);
    for (int i = 0; i < TB_TO - 1; i++) idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.balance !== 8'd2) begin
      n_fail++;
      $display("FAIL timeout_restart actual=chg%b busy%b bal%0d required=0/1/2",
               bus_if.change_valid, bus_if.busy, bus_if.balance);
    end
    idle();
    n_checks++;
    if (bus_if.change_valid !== 1'b1 || bus_if.change !== 8'd2) begin
      n_fail++;
      $display("FAIL timeout_refund2 actual=%b/%0d required=1/2", bus_if.change_valid, bus_if.change);
    end
    idle();
  endtask
`else
  task automatic test_no_timeout();
    step(4'b0001, 0, 0, 0, 0);
    step(4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 3 * TB_TO; i++) idle();
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.change_valid !== 1'b0 || bus_if.balance !== 8'd1) begin
      n_fail++;
      $display("FAIL sel_held actual=busy%b chg%b bal%0d required=1/0/1",
               bus_if.busy, bus_if.change_valid, bus_if.balance);
    end
    step(4'd0, 0, 0, 0, 1);
    idle();
  endtask
`endif

  task automatic test_random();
    logic [3:0] it;
    logic c1, c5, cf, cc;
    int ev;
    for (int n = 0; n < 600; n++) begin
      it = 4'd0; c1 = 0; c5 = 0; cf = 0; cc = 0;
      ev = int'($urandom_range(0, 15));
      case (ev)
        4:       it = 4'($urandom_range(1, 15));
        5:       it = 4'(1 << $urandom_range(0, 3));
        6, 7:    c1 = 1;
        8, 9:    c5 = 1;
        10:      begin c1 = 1; c5 = 1; end
        11:      cf = 1;
        12:      cc = 1;
        13:      begin cc = 1; cf = 1; end
        default: ;
      endcase
      step(it, c1, c5, cf, cc);
      n_checks++;
      if (observe() !== exp_f) begin
        n_fail++;
        $display("FAIL random_cycle%0d actual=%h required=%h", n, observe(), exp_f);
      end
    end
  endtask

  initial begin
    bus_if.key_item    = 4'd0;
    bus_if.key_coin1   = 1'b0;
    bus_if.key_coin5   = 1'b0;
    bus_if.key_confirm = 1'b0;
    bus_if.key_cancel  = 1'b0;
    model_clear();
    exp_f = '0;
    test_reset();
    test_reset_mid_sel();
    test_vend_change();
    test_insufficient();
    test_cancel_priority();
    test_saturation();
    test_back_to_back();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
